// File: rtl/forney_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined Forney evaluator between the
// Chien-search lanes. Grants are registered toward the evaluator behind a
// valid/ready handshake; in-flight jobs are tracked per tag under a credit
// limit, and results are routed back as one-cycle done pulses.
module forney_rr_scheduler #(
    parameter int REQ_NB       = 32,
    parameter int DATA_W       = 10,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3,
    parameter int TAG_W        = $clog2(REQ_NB)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     flush_i,
    input  logic [REQ_NB-1:0]        req_i,
    input  logic [REQ_NB*DATA_W-1:0] req_data_i,
    output logic [REQ_NB-1:0]        ack_o,
    output logic                     iss_valid_o,
    input  logic                     iss_ready_i,
    output logic [TAG_W-1:0]         iss_tag_o,
    output logic [DATA_W-1:0]        iss_data_o,
    input  logic                     res_valid_i,
    input  logic [TAG_W-1:0]         res_tag_i,
    input  logic [DATA_W-1:0]        res_data_i,
    output logic [REQ_NB-1:0]        done_o,
    output logic [DATA_W-1:0]        done_data_o,
    output logic [CNT_W-1:0]         inflight_o,
    output logic                     busy_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [TAG_W-1:0]    ptr;
    logic [REQ_NB-1:0]   pending;
    logic [REQ_NB-1:0]   eligible;
    logic [REQ_NB-1:0]   grant_oh;
    logic [REQ_NB-1:0]   ret_oh;
    logic                can_grant;
    logic                found;
    logic                grant;
    logic [TAG_W-1:0]    grant_idx;
    logic                ret_ok;
    logic                spurious;

    // A requester already holding a job cannot be granted again until it returns.
    assign eligible  = req_i & ~pending;
    // The output register may be refilled in the same cycle it hands off.
    assign can_grant = (state == RUN) && (inflight_o < CNT_W'(MAX_INFLIGHT)) &&
                       (!iss_valid_o || iss_ready_i);
    assign grant     = can_grant && found;
    assign ret_ok    = res_valid_i && pending[res_tag_i];
    assign spurious  = res_valid_i && !pending[res_tag_i];
    assign busy_o    = (state != IDLE) || (inflight_o != '0);

    // Round-robin search: first eligible index at or after ptr, wrapping.
    always_comb begin
        logic [TAG_W:0]   sum;
        logic [TAG_W-1:0] idx;
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < REQ_NB; k++) begin
            sum = {1'b0, ptr} + (TAG_W+1)'(k);
            if (sum >= (TAG_W+1)'(REQ_NB)) sum = sum - (TAG_W+1)'(REQ_NB);
            idx = sum[TAG_W-1:0];
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // One-hot decode of the granted index and the returning tag.
    always_comb begin
        grant_oh = '0;
        ret_oh   = '0;
        if (grant)  grant_oh[grant_idx] = 1'b1;
        if (ret_ok) ret_oh[res_tag_i]   = 1'b1;
    end

    // Sequencing: RUN grants, DRAIN waits for every outstanding job to return.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_i && !flush_i)     state_nxt = RUN;
            RUN:     if (flush_i || !en_i)     state_nxt = DRAIN;
            DRAIN:   if (inflight_o == '0)     state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Pointer, pending mask and credit counter; a grant and a return in the
    // same cycle cancel out on the counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr        <= '0;
            pending    <= '0;
            inflight_o <= '0;
        end else begin
            pending <= (pending | grant_oh) & ~ret_oh;
            if (grant)
                ptr <= (grant_idx == TAG_W'(REQ_NB-1)) ? '0 : grant_idx + TAG_W'(1);
            case ({grant, ret_ok})
                2'b10:   inflight_o <= inflight_o + CNT_W'(1);
                2'b01:   inflight_o <= inflight_o - CNT_W'(1);
                default: inflight_o <= inflight_o;
            endcase
        end
    end

    // Issue register toward the evaluator; holds tag/data under backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iss_valid_o <= 1'b0;
            iss_tag_o   <= '0;
            iss_data_o  <= '0;
            ack_o       <= '0;
        end else begin
            ack_o <= grant_oh;
            if (grant) begin
                iss_valid_o <= 1'b1;
                iss_tag_o   <= grant_idx;
                iss_data_o  <= req_data_i[grant_idx*DATA_W +: DATA_W];
            end else if (iss_ready_i) begin
                iss_valid_o <= 1'b0;
            end
        end
    end

    // Result return pulses and sticky error on results for idle tags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_o      <= '0;
            done_data_o <= '0;
            err_o       <= 1'b0;
        end else begin
            done_o <= ret_oh;
            if (ret_ok)   done_data_o <= res_data_i;
            if (spurious) err_o       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_forney_rr_scheduler.sv
// Self-checking bench for forney_rr_scheduler: directed scenarios plus a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_forney_rr_scheduler;
    localparam int REQ_NB       = 32;
    localparam int DATA_W       = 10;
    localparam int MAX_INFLIGHT = 4;
    localparam int CNT_W        = 3;
    localparam int TAG_W        = 5;

    logic                     clk = 1'b0;
    logic                     rst, en, flush, iss_ready, res_valid;
    logic [REQ_NB-1:0]        req;
    logic [REQ_NB*DATA_W-1:0] req_data;
    logic [TAG_W-1:0]         res_tag;
    logic [DATA_W-1:0]        res_data;
    logic [REQ_NB-1:0]        ack, done;
    logic                     iss_valid, busy, err;
    logic [TAG_W-1:0]         iss_tag;
    logic [DATA_W-1:0]        iss_data, done_data;
    logic [CNT_W-1:0]         inflight;

    forney_rr_scheduler #(
        .REQ_NB(REQ_NB), .DATA_W(DATA_W), .MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
        .req_i(req), .req_data_i(req_data), .ack_o(ack),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready), .iss_tag_o(iss_tag),
        .iss_data_o(iss_data), .res_valid_i(res_valid), .res_tag_i(res_tag),
        .res_data_i(res_data), .done_o(done), .done_data_o(done_data),
        .inflight_o(inflight), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: state 0=idle 1=run 2=drain.
    int                 m_state, m_ptr, m_infl, m_itag;
    bit [REQ_NB-1:0]    m_pend, m_ack, m_done;
    bit                 m_ivld, m_err;
    bit [DATA_W-1:0]    m_idata, m_ddata;

    // Evaluator stand-in: FIFO of accepted tags with earliest return cycle.
    int q_tag[$];
    int q_due[$];
    int cyc = 0;
    int lat_max = 0;
    int seq[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [REQ_NB-1:0] v);
        int r = -1;
        for (int k = 0; k < REQ_NB; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_infl = 0; m_itag = 0;
        m_pend = '0; m_ack = '0; m_done = '0;
        m_ivld = 1'b0; m_err = 1'b0; m_idata = '0; m_ddata = '0;
        q_tag.delete(); q_due.delete();
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_eval();
        int g, nstate, ti;
        bit ret, spur;
        g  = -1;
        ti = int'(res_tag);
        if (m_state == 1 && m_infl < MAX_INFLIGHT && (!m_ivld || iss_ready)) begin
            for (int k = 0; k < REQ_NB; k++) begin
                int idx;
                idx = (m_ptr + k) % REQ_NB;
                if (g < 0 && req[idx] && !m_pend[idx]) g = idx;
            end
        end
        ret  = res_valid && m_pend[ti];
        spur = res_valid && !m_pend[ti];
        nstate = m_state;
        if (m_state == 0 && en && !flush)       nstate = 1;
        else if (m_state == 1 && (flush || !en)) nstate = 2;
        else if (m_state == 2 && m_infl == 0)    nstate = 0;
        m_ack  = '0;
        m_done = '0;
        if (g >= 0) begin
            m_ack[g]  = 1'b1;
            m_pend[g] = 1'b1;
            m_ptr     = (g + 1) % REQ_NB;
            m_infl    = m_infl + 1;
            m_ivld    = 1'b1;
            m_itag    = g;
            m_idata   = req_data[g*DATA_W +: DATA_W];
        end else if (iss_ready) begin
            m_ivld = 1'b0;
        end
        if (ret) begin
            m_done[ti] = 1'b1;
            m_ddata    = res_data;
            m_pend[ti] = 1'b0;
            m_infl     = m_infl - 1;
        end
        if (spur) m_err = 1'b1;
        m_state = nstate;
    endtask

    task automatic check_all();
        chk("ack", ack, m_ack);
        chk("iss_valid", 32'(iss_valid), 32'(m_ivld));
        if (m_ivld) begin
            chk("iss_tag", 32'(iss_tag), 32'(m_itag));
            chk("iss_data", 32'(iss_data), 32'(m_idata));
        end
        chk("done", done, m_done);
        if (m_done != '0) chk("done_data", 32'(done_data), 32'(m_ddata));
        chk("inflight", 32'(inflight), 32'(m_infl));
        chk("busy", 32'(busy), 32'(m_state != 0 || m_infl != 0));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic chk_zero(input string pre);
        chk({pre, "_ack"}, ack, 32'h0);
        chk({pre, "_iss_valid"}, 32'(iss_valid), 32'h0);
        chk({pre, "_iss_tag"}, 32'(iss_tag), 32'h0);
        chk({pre, "_iss_data"}, 32'(iss_data), 32'h0);
        chk({pre, "_done"}, done, 32'h0);
        chk({pre, "_done_data"}, 32'(done_data), 32'h0);
        chk({pre, "_inflight"}, 32'(inflight), 32'h0);
        chk({pre, "_busy"}, 32'(busy), 32'h0);
        chk({pre, "_err"}, 32'(err), 32'h0);
    endtask

    task automatic rand_data();
        for (int k = 0; k < REQ_NB; k++) req_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    // One clock: model predicts, DUT clocks, outputs compared 1 time unit later.
    task automatic step();
        bit hs;
        int t;
        hs = iss_valid && iss_ready;
        t  = int'(iss_tag);
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            q_tag.push_back(t);
            q_due.push_back(cyc + int'($urandom_range(0, lat_max)));
        end
        check_all();
    endtask

    task automatic drive_res(input bit spur_en, input int pop_pct);
        res_valid = 1'b0;
        res_tag   = '0;
        res_data  = DATA_W'($urandom);
        if (q_tag.size() > 0 && q_due[0] <= cyc && int'($urandom_range(0, 99)) < pop_pct) begin
            res_valid = 1'b1;
            res_tag   = TAG_W'(q_tag.pop_front());
            void'(q_due.pop_front());
        end else if (spur_en && $urandom_range(0, 99) < 2) begin
            res_valid = 1'b1;
            res_tag   = TAG_W'($urandom);
        end
    endtask

    task automatic reset_dut(input string pre);
        rst = 1'b1; en = 1'b0; flush = 1'b0; req = '0; iss_ready = 1'b1;
        res_valid = 1'b0; res_tag = '0; res_data = '0;
        rand_data();
        model_reset();
        #1;
        chk_zero(pre);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int c3, c6, bad, acc;
        logic [DATA_W-1:0] held;

        // Single request end to end.
        reset_dut("rst");
        en = 1'b1; step();
        req = 32'h10; req_data[4*DATA_W +: DATA_W] = 10'h155; step();
        chk("t1_ack", ack, 32'h10);
        chk("t1_tag", 32'(iss_tag), 32'd4);
        chk("t1_data", 32'(iss_data), 32'h155);
        req = '0; step(); step(); step();
        res_valid = 1'b1; res_tag = 5'd4; res_data = 10'h2AA; step();
        chk("t1_done", done, 32'h10);
        chk("t1_done_data", 32'(done_data), 32'h2AA);
        res_valid = 1'b0; step();
        chk("t1_inflight", 32'(inflight), 32'd0);

        // Fairness between requesters 3 and 6 with immediate results.
        reset_dut("rst2");
        en = 1'b1; step();
        req = 32'h48; lat_max = 0; seq.delete();
        for (int i = 0; i < 64; i++) begin
            drive_res(1'b0, 100);
            step();
            if (ack != '0) seq.push_back(oh_idx(ack));
        end
        res_valid = 1'b0;
        bad = 0; c3 = 0; c6 = 0;
        foreach (seq[i]) begin
            if (seq[i] == 3) c3++;
            else if (seq[i] == 6) c6++;
            else bad++;
            if (i > 0 && seq[i] == seq[i-1]) bad++;
        end
        chk("t2_alternate", 32'(bad), 32'd0);
        chk("t2_first", 32'(seq.size() > 0 ? seq[0] : -1), 32'd3);
        chk("t2_balance", 32'((c3 - c6 <= 1) && (c6 - c3 <= 1)), 32'd1);
        chk("t2_volume", 32'(seq.size() >= 16), 32'd1);

        // Credit limit with all requesters active and nothing returning.
        reset_dut("rst3");
        en = 1'b1; step();
        req = '1; acc = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            acc = acc | int'(ack);
            if (ack != '0) bad++;
        end
        chk("t3_grant_mask", 32'(acc), 32'hF);
        chk("t3_grant_count", 32'(bad), 32'd4);
        chk("t3_inflight", 32'(inflight), 32'd4);
        chk("t3_no_issue", 32'(iss_valid), 32'd0);
        res_valid = 1'b1; res_tag = 5'd1; step();
        res_valid = 1'b0; step();
        chk("t3_regrant", ack, 32'h10);

        // Backpressure holds the issue register and the pointer.
        reset_dut("rst4");
        en = 1'b1; step();
        req = 32'h200; iss_ready = 1'b0; step();
        chk("t4_ack", ack, 32'h200);
        held = iss_data;
        req = 32'h604;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step();
            chk("t4_tag_hold", 32'(iss_tag), 32'd9);
            chk("t4_data_hold", 32'(iss_data), 32'(held));
            chk("t4_no_ack", ack, 32'h0);
        end
        iss_ready = 1'b1; step();
        chk("t4_next_grant", ack, 32'h400);

        // Flush with three jobs outstanding.
        reset_dut("rst5");
        en = 1'b1; step();
        req = 32'h7; step(); step(); step();
        req = '0;
        chk("t5_inflight", 32'(inflight), 32'd3);
        flush = 1'b1; step();
        flush = 1'b0; en = 1'b0; req = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_grant", ack, 32'h0);
            chk("t5_busy", 32'(busy), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_tag = TAG_W'(i); step();
        end
        res_valid = 1'b0;
        for (int i = 0; i < 4 && busy; i++) step();
        chk("t5_idle", 32'(busy), 32'd0);

        // Spurious result, then asynchronous reset mid-run.
        reset_dut("rst6");
        en = 1'b1; step();
        res_valid = 1'b1; res_tag = 5'd17; step();
        res_valid = 1'b0;
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_no_done", done, 32'h0);
        req = 32'h20; step();
        chk("t6_ack", ack, 32'h20);
        step();
        #3;
        rst = 1'b1;
        #1;
        chk_zero("t6_async");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0; req = '0;
        res_valid = 1'b1; res_tag = 5'd5; step();
        res_valid = 1'b0;
        chk("t6_err_after_reset", 32'(err), 32'd1);

        // Randomized traffic against the model.
        reset_dut("rst7");
        lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom_range(0, 99) < 97);
            flush     = ($urandom_range(0, 99) < 2);
            iss_ready = ($urandom_range(0, 3) != 0);
            req       = REQ_NB'($urandom & $urandom);
            rand_data();
            drive_res(1'b1, 60);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
